// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, memory opcodes and stage FSM encodings.
package mem_access_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam int ByteSel = 4;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;
  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_DONE} mem_state_e;
endpackage

// File: rtl/mem_access_align.sv
// mem_align: byte-lane select, store replication, load extension and misalignment check.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]         op,
  input  logic [1:0]         off,
  input  logic [31:0]        sdata,
  input  logic [31:0]        rdata,
  output logic               is_mem,
  output logic               is_store,
  output logic               is_load,
  output logic               misalign,
  output logic [ByteSel-1:0] sel,
  output logic [31:0]        wdata,
  output logic [31:0]        ldata
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_load = op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    is_store = op inside {MEM_SB, MEM_SH, MEM_SW};
    is_mem = is_load | is_store;
    misalign = ((op inside {MEM_LH, MEM_LHU, MEM_SH}) & off[0]) | ((op inside {MEM_LW, MEM_SW}) & (|off));
    sel = op == MEM_SB ? 4'b0001 << off : op == MEM_SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = op == MEM_SB ? {4{sdata[7:0]}} : op == MEM_SH ? {2{sdata[15:0]}} : op == MEM_SW ? sdata : '0;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    ldata = op == MEM_LB  ? {{24{b[7]}}, b}  :
            op == MEM_LBU ? {24'b0, b}       :
            op == MEM_LH  ? {{16{h[15]}}, h} :
            op == MEM_LHU ? {16'b0, h}       : rdata;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage controller running loads/stores as a req/ack bus transaction with timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [RegBus-1:0]     mem_hi,
  input  logic [RegBus-1:0]     mem_lo,
  input  logic                  mem_we,
  input  logic [RegBus-1:0]     mem_flags,
  input  logic [3:0]            mem_op,
  input  logic [31:0]           mem_addr,
  input  logic [RegBus-1:0]     mem_sdata,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [31:0]           dbus_addr,
  output logic [31:0]           dbus_wdata,
  output logic [ByteSel-1:0]    dbus_sel,
  input  logic                  dbus_ack,
  input  logic [31:0]           dbus_rdata,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic [RegBus-1:0]     wb_hi,
  output logic [RegBus-1:0]     wb_lo,
  output logic                  wb_we,
  output logic [RegBus-1:0]     wb_flags,
  output logic                  stallreq,
  output logic                  exc_misalign,
  output logic                  exc_buserr
);
  localparam logic [7:0] Tmo = 8'(TIMEOUT_CYCLES);
  mem_state_e state;
  logic [7:0] cnt;
  logic [31:0] ldata_q;
  logic buserr_q;
  logic is_mem, is_store, is_load, misalign, valid, done;
  logic [ByteSel-1:0] lane_sel;
  logic [31:0] lane_wdata, lane_ldata;
  mem_align u_align (
    .op(mem_op), .off(mem_addr[1:0]), .sdata(mem_sdata), .rdata(dbus_rdata),
    .is_mem(is_mem), .is_store(is_store), .is_load(is_load), .misalign(misalign),
    .sel(lane_sel), .wdata(lane_wdata), .ldata(lane_ldata)
  );
  assign valid = is_mem & ~misalign;
  assign done = state == MEM_DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= MEM_IDLE;
      dbus_req <= 1'b0;
      dbus_we <= 1'b0;
      dbus_addr <= '0;
      dbus_wdata <= '0;
      dbus_sel <= '0;
      ldata_q <= '0;
      buserr_q <= 1'b0;
      cnt <= '0;
    end else
      case (state)
        MEM_IDLE: if (valid) begin
          state <= MEM_WAIT;
          dbus_req <= 1'b1;
          dbus_we <= is_store;
          dbus_addr <= {mem_addr[31:2], 2'b00};
          dbus_wdata <= lane_wdata;
          dbus_sel <= lane_sel;
          cnt <= '0;
        end
        MEM_WAIT: if (dbus_ack) begin
          state <= MEM_DONE;
          dbus_req <= 1'b0;
          ldata_q <= lane_ldata;
        end else if (cnt == Tmo) begin
          state <= MEM_DONE;
          dbus_req <= 1'b0;
          buserr_q <= 1'b1;
        end else
          cnt <= cnt + 8'd1;
        default: begin
          state <= MEM_IDLE;
          buserr_q <= 1'b0;
        end
      endcase
  // wb_wreg is suppressed while stalled so mem_wb only sees bubbles until DONE
  always_comb begin
    stallreq = !rst && (state == MEM_WAIT || (state == MEM_IDLE && valid));
    exc_misalign = !rst && state == MEM_IDLE && misalign;
    exc_buserr = !rst && done && buserr_q;
    wb_wd = rst ? NOPRegAddr : mem_wd;
    wb_wdata = rst ? '0 : (done && is_load) ? ldata_q : mem_wdata;
    wb_hi = rst ? '0 : mem_hi;
    wb_lo = rst ? '0 : mem_lo;
    wb_we = !rst && mem_we;
    wb_flags = rst ? '0 : mem_flags;
    wb_wreg = !rst && mem_wreg && !stallreq && !exc_misalign && !(done && (is_store || buserr_q));
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access with a 4-cycle timeout.
module tb_mem_access;
  import mem_access_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RegAddrBus-1:0] mem_wd = '0, wb_wd;
  logic mem_wreg = 1'b0, mem_we = 1'b0, wb_wreg, wb_we;
  logic [31:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0, mem_flags = '0, mem_addr = '0, mem_sdata = '0;
  logic [3:0] mem_op = MEM_NOP;
  logic dbus_req, dbus_we, dbus_ack = 1'b0;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
  logic [3:0] dbus_sel;
  logic [31:0] wb_wdata, wb_hi, wb_lo, wb_flags;
  logic stallreq, exc_misalign, exc_buserr;
  int n_cmp = 0, n_err = 0, stall_n = 0;
  logic s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_sel;
  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_we(mem_we), .mem_flags(mem_flags), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_sdata(mem_sdata), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_sel(dbus_sel), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_we(wb_we), .wb_flags(wb_flags), .stallreq(stallreq),
    .exc_misalign(exc_misalign), .exc_buserr(exc_buserr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Presents one memory op, acks ack_n cycles after req rises (negative: never), returns in DONE.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int ack_n);
    mem_op = op;
    mem_addr = addr;
    mem_sdata = sdata;
    dbus_rdata = rdata;
    stall_n = 0;
    for (int k = 0; k < 300; k++) begin
      dbus_ack = ack_n >= 0 && k == ack_n + 1;
      #1;
      if (k == 1) begin
        s_req = dbus_req; s_we = dbus_we; s_addr = dbus_addr; s_wdata = dbus_wdata; s_sel = dbus_sel;
      end
      if (!stallreq) break;
      stall_n++;
      @(posedge clk);
      #1;
    end
    dbus_ack = 1'b0;
    #1;
  endtask
  initial begin
    mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hAAAA_5555; mem_hi = 32'h11; mem_lo = 32'h22;
    mem_we = 1'b1; mem_flags = 32'h5;
    step();
    step();
    chk("rst_wb_wd", 32'(wb_wd), 32'(NOPRegAddr));
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_wb_wreg", 32'(wb_wreg), 0);
    chk("rst_wb_hi", wb_hi, 0);
    chk("rst_stall", 32'(stallreq), 0);
    chk("rst_dbus_req", 32'(dbus_req), 0);
    chk("rst_dbus_sel", 32'(dbus_sel), 0);
    rst = 1'b0;
    mem_wdata = 32'h1234_5678;
    #1;
    chk("pt_wdata", wb_wdata, 32'h1234_5678);
    chk("pt_wreg", 32'(wb_wreg), 1);
    chk("pt_wd", 32'(wb_wd), 7);
    chk("pt_flags", wb_flags, 5);
    chk("pt_stall", 32'(stallreq), 0);
    step();
    chk("pt_dbus_req", 32'(dbus_req), 0);
    mem_wdata = 32'hDEAD_0001;
    access(MEM_LB, 32'h1003, 0, 32'h80FF_0000, 2);
    chk("lb_addr", s_addr, 32'h1000);
    chk("lb_req", 32'(s_req), 1);
    chk("lb_sel", 32'(s_sel), 4'hF);
    chk("lb_stall_cycles", stall_n, 4);
    chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_wreg", 32'(wb_wreg), 1);
    chk("lb_done_req", 32'(dbus_req), 0);
    mem_op = MEM_NOP;
    step();
    chk("lb_idle_stall", 32'(stallreq), 0);
    access(MEM_LBU, 32'h1003, 0, 32'h80FF_0000, 2);
    chk("lbu_stall_cycles", stall_n, 4);
    chk("lbu_wdata", wb_wdata, 32'h0000_0080);
    mem_op = MEM_NOP;
    step();
    mem_wdata = 32'h0000_0055;
    access(MEM_SH, 32'h2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 0);
    chk("sh_sel", 32'(s_sel), 4'b1100);
    chk("sh_dbus_wdata", s_wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(s_we), 1);
    chk("sh_addr", s_addr, 32'h2000);
    chk("sh_stall_cycles", stall_n, 2);
    chk("sh_wreg", 32'(wb_wreg), 0);
    chk("sh_wb_wdata", wb_wdata, 32'h0000_0055);
    mem_op = MEM_NOP;
    step();
    access(MEM_SB, 32'h6001, 32'h1234_56A5, 0, 1);
    chk("sb_sel", 32'(s_sel), 4'b0010);
    chk("sb_dbus_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("sb_stall_cycles", stall_n, 3);
    mem_op = MEM_NOP;
    step();
    access(MEM_LH, 32'h7002, 0, 32'h8001_1234, 1);
    chk("lh_wdata", wb_wdata, 32'hFFFF_8001);
    mem_op = MEM_NOP;
    step();
    access(MEM_LHU, 32'h7000, 0, 32'h8001_F234, 0);
    chk("lhu_wdata", wb_wdata, 32'h0000_F234);
    mem_op = MEM_NOP;
    step();
    mem_op = MEM_LW;
    mem_addr = 32'h3001;
    #1;
    chk("mis_exc", 32'(exc_misalign), 1);
    chk("mis_wreg", 32'(wb_wreg), 0);
    chk("mis_stall", 32'(stallreq), 0);
    chk("mis_wdata", wb_wdata, 32'h0000_0055);
    step();
    chk("mis_dbus_req", 32'(dbus_req), 0);
    access(MEM_LW, 32'h4000, 0, 32'h1111_1111, -1);
    chk("to_stall_cycles", stall_n, 6);
    chk("to_buserr", 32'(exc_buserr), 1);
    chk("to_wreg", 32'(wb_wreg), 0);
    chk("to_dbus_req", 32'(dbus_req), 0);
    mem_op = MEM_NOP;
    step();
    chk("to_idle_buserr", 32'(exc_buserr), 0);
    chk("to_idle_wreg", 32'(wb_wreg), 1);
    mem_op = MEM_LW;
    mem_addr = 32'h5000;
    dbus_rdata = 32'hCAFE_F00D;
    step();
    step();
    chk("rw_wait_req", 32'(dbus_req), 1);
    rst = 1'b1;
    #1;
    chk("rw_rst_stall", 32'(stallreq), 0);
    chk("rw_rst_wdata", wb_wdata, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rw_after_req", 32'(dbus_req), 0);
    chk("rw_after_sel", 32'(dbus_sel), 0);
    chk("rw_idle_stall", 32'(stallreq), 1);
    access(MEM_LW, 32'h5000, 0, 32'hCAFE_F00D, 1);
    chk("rw_lw_stall_cycles", stall_n, 3);
    chk("rw_lw_wdata", wb_wdata, 32'hCAFE_F00D);
    chk("rw_lw_wreg", 32'(wb_wreg), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
